// File: rtl/logicunit_pipe_if.sv
// -----------------------------------------------------------------------------
// logicunit_pipe_if
// Bundles the upstream operation handshake, the downstream result handshake
// and the accumulator observation port of logicunit_pipe.
//
// Signals
//   in_valid / in_ready    : operation handshake (upstream -> block)
//   x, y                   : operands, WIDTH bits each
//   control                : 0 AND, 1 OR, 2 NOR, 3 XOR
//   acc_en, acc_clr        : use accumulator as first operand / clear it
//   out_valid / out_ready  : result handshake (block -> downstream)
//   out, zero              : oldest undelivered result and its all-zero flag
//   acc                    : current accumulator value
//
// Modports
//   master : the side that issues operations and consumes results
//   slave  : the logic unit pipeline itself
// -----------------------------------------------------------------------------
interface logicunit_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [1:0]       control;
  logic             acc_en;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, x, y, control, acc_en, acc_clr, out_ready,
    input  in_ready, out_valid, out, zero, acc
  );

  modport slave (
    input  in_valid, x, y, control, acc_en, acc_clr, out_ready,
    output in_ready, out_valid, out, zero, acc
  );
endinterface

// File: rtl/logicunit_pipe.sv
// -----------------------------------------------------------------------------
// logicunit_pipe
// Pipelined bitwise logic unit with an accumulator and valid/ready flow
// control on both sides.  Each accepted operation computes
// r = f(a, y) with a = acc_en ? (acc_clr ? 0 : acc) : x, then travels through
// DEPTH result stages before appearing on out.  The accumulator captures r on
// every accepted operation.
//
// Parameters
//   WIDTH : operand / result width (1..64)
//   DEPTH : number of result pipeline stages (1..4), which is also the
//           number of operations the block can hold
//
// Ports
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : logicunit_pipe_if slave modport (handshakes, operands, results)
// -----------------------------------------------------------------------------
module logicunit_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic             clock,
  input logic             reset,
  logicunit_pipe_if.slave bus
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] result;
  logic             accept;

  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_zero;
  logic [WIDTH-1:0] stage_data [DEPTH];

  // room[i] means stage i can take a new entry this cycle; room[DEPTH] is the
  // downstream consumer, so the last stage drains exactly on deliver.
  logic [DEPTH:0]   room;
  logic [DEPTH-1:0] adv;

  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] load_zero;
  logic [WIDTH-1:0] load_data [DEPTH];

  // Operand select and the bitwise function.  acc_clr forces the accumulator
  // operand to zero in the same cycle it is used.
  always_comb begin
    operand_a = bus.x;
    if (bus.acc_en) begin
      operand_a = bus.acc_clr ? '0 : acc_q;
    end
    result = '0;
    unique case (bus.control)
      2'd0: result = operand_a & bus.y;
      2'd1: result = operand_a | bus.y;
      2'd2: result = ~(operand_a | bus.y);
      2'd3: result = operand_a ^ bus.y;
      default: result = '0;
    endcase
  end

  // Advance chain, evaluated from the output back toward the input so each
  // stage sees whether its successor is empty or moving on this cycle.
  always_comb begin
    room        = '0;
    adv         = '0;
    room[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i]  = stage_valid[i] & room[i+1];
      room[i] = ~stage_valid[i] | adv[i];
    end
  end

  assign accept = bus.in_valid & room[0];

  // What each stage would capture this cycle: stage 0 takes the fresh result,
  // later stages take their predecessor when it advances.
  always_comb begin
    load      = '0;
    load_zero = '0;
    for (int i = 0; i < DEPTH; i++) begin
      load_data[i] = '0;
    end
    load[0]      = accept;
    load_data[0] = result;
    load_zero[0] = (result == '0);
    for (int i = 1; i < DEPTH; i++) begin
      load[i]      = adv[i-1];
      load_data[i] = stage_data[i-1];
      load_zero[i] = stage_zero[i-1];
    end
  end

  // Stage registers.  Data and zero flag only change when an entry moves in,
  // so the last stage keeps showing its final result once it drains.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_valid <= '0;
      stage_zero  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stage_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (load[i]) begin
          stage_valid[i] <= 1'b1;
          stage_data[i]  <= load_data[i];
          stage_zero[i]  <= load_zero[i];
        end else if (adv[i]) begin
          stage_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Accumulator: an accept always wins (its result already honours acc_clr);
  // a clear on its own empties the accumulator.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= result;
    end else if (bus.acc_clr) begin
      acc_q <= '0;
    end
  end

  assign bus.in_ready  = room[0];
  assign bus.out_valid = stage_valid[DEPTH-1];
  assign bus.out       = stage_data[DEPTH-1];
  assign bus.zero      = stage_zero[DEPTH-1];
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_logicunit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logicunit_pipe
// Directed self-checking bench for logicunit_pipe with WIDTH=8, DEPTH=2.
// Inputs are driven 1 time unit after each rising edge and outputs are
// observed at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_logicunit_pipe;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  logicunit_pipe_if #(.WIDTH(8)) bus ();

  logicunit_pipe #(
    .WIDTH (8),
    .DEPTH (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL reset_handshake: got %b expected 01", {bus.out_valid, bus.in_ready});
    end
    checks++;
    if ({bus.out, bus.acc} !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_out_acc: got %h expected 0000", {bus.out, bus.acc});
    end
    step();
    step();
    reset = 1'b0;
    step();
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL reset_release: got %b expected 01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_ops();
    logic [7:0] expv [4];
    expv[0] = 8'h0A;
    expv[1] = 8'hCF;
    expv[2] = 8'h30;
    expv[3] = 8'hC5;
    bus.out_ready = 1'b1;
    bus.x         = 8'hCA;
    bus.y         = 8'h0F;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.control = k[1:0];
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL ops_in_ready[%0d]: got %b expected 1", k, bus.in_ready);
      end
      step();
      if (k == 0) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL ops_latency: got out_valid %b expected 0", bus.out_valid);
        end
      end else begin
        checks++;
        if ({bus.out_valid, bus.out, bus.zero} !== {1'b1, expv[k-1], 1'b0}) begin
          errors++;
          $display("[TB] FAIL ops_result[%0d]: got v=%b out=%h z=%b expected v=1 out=%h z=0",
                   k - 1, bus.out_valid, bus.out, bus.zero, expv[k-1]);
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.x        = 8'h5A;
    bus.y        = 8'hA5;
    step();
    checks++;
    if ({bus.out_valid, bus.out, bus.zero} !== {1'b1, expv[3], 1'b0}) begin
      errors++;
      $display("[TB] FAIL ops_result[3]: got v=%b out=%h z=%b expected v=1 out=%h z=0",
               bus.out_valid, bus.out, bus.zero, expv[3]);
    end
    step();
    checks++;
    if ({bus.out_valid, bus.out, bus.acc} !== {1'b0, 8'hC5, 8'hC5}) begin
      errors++;
      $display("[TB] FAIL ops_drained: got v=%b out=%h acc=%h expected v=0 out=c5 acc=c5",
               bus.out_valid, bus.out, bus.acc);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.x = 8'h11; bus.y = 8'h22; bus.control = 2'd1;
    step();
    bus.x = 8'h44; bus.y = 8'h0F; bus.control = 2'd0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_second_ready: got %b expected 1", bus.in_ready);
    end
    step();
    bus.x = 8'h55; bus.y = 8'hFF; bus.control = 2'd3;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_full: got in_ready %b expected 0", bus.in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({bus.out_valid, bus.out, bus.zero, bus.in_ready} !== {1'b1, 8'h33, 1'b0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b out=%h z=%b rdy=%b expected v=1 out=33 z=0 rdy=0",
                 k, bus.out_valid, bus.out, bus.zero, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release_ready: got %b expected 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_valid, bus.out} !== {1'b1, 8'h04}) begin
      errors++;
      $display("[TB] FAIL bp_order[1]: got v=%b out=%h expected v=1 out=04", bus.out_valid, bus.out);
    end
    step();
    checks++;
    if ({bus.out_valid, bus.out} !== {1'b1, 8'hAA}) begin
      errors++;
      $display("[TB] FAIL bp_order[2]: got v=%b out=%h expected v=1 out=aa", bus.out_valid, bus.out);
    end
    step();
    checks++;
    if ({bus.out_valid, bus.out} !== {1'b0, 8'hAA}) begin
      errors++;
      $display("[TB] FAIL bp_empty: got v=%b out=%h expected v=0 out=aa", bus.out_valid, bus.out);
    end
  endtask

  task automatic test_accumulate();
    logic [7:0] ys   [4];
    logic [1:0] ctl  [4];
    logic [7:0] expv [4];
    ys[0] = 8'h01; ys[1] = 8'h02; ys[2] = 8'h04; ys[3] = 8'hFF;
    ctl[0] = 2'd1; ctl[1] = 2'd1; ctl[2] = 2'd1; ctl[3] = 2'd3;
    expv[0] = 8'h01; expv[1] = 8'h03; expv[2] = 8'h07; expv[3] = 8'hF8;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.acc_en    = 1'b1;
    bus.x         = 8'hAA;
    for (int k = 0; k < 4; k++) begin
      bus.acc_clr = (k == 0);
      bus.y       = ys[k];
      bus.control = ctl[k];
      step();
      checks++;
      if (bus.acc !== expv[k]) begin
        errors++;
        $display("[TB] FAIL acc_value[%0d]: got %h expected %h", k, bus.acc, expv[k]);
      end
      if (k > 0) begin
        checks++;
        if ({bus.out_valid, bus.out} !== {1'b1, expv[k-1]}) begin
          errors++;
          $display("[TB] FAIL acc_out[%0d]: got v=%b out=%h expected v=1 out=%h",
                   k - 1, bus.out_valid, bus.out, expv[k-1]);
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b0;
    step();
    checks++;
    if ({bus.out_valid, bus.out, bus.acc} !== {1'b1, 8'hF8, 8'hF8}) begin
      errors++;
      $display("[TB] FAIL acc_final: got v=%b out=%h acc=%h expected v=1 out=f8 acc=f8",
               bus.out_valid, bus.out, bus.acc);
    end
    bus.acc_clr = 1'b1;
    step();
    bus.acc_clr = 1'b0;
    bus.acc_en  = 1'b0;
    checks++;
    if (bus.acc !== 8'h00) begin
      errors++;
      $display("[TB] FAIL acc_clear_idle: got %h expected 00", bus.acc);
    end
  endtask

  task automatic test_zero();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.x = 8'hF0; bus.y = 8'h0F; bus.control = 2'd0;
    step();
    bus.control = 2'd1;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_valid, bus.out, bus.zero} !== {1'b1, 8'h00, 1'b1}) begin
      errors++;
      $display("[TB] FAIL zero_set: got v=%b out=%h z=%b expected v=1 out=00 z=1",
               bus.out_valid, bus.out, bus.zero);
    end
    step();
    checks++;
    if ({bus.out_valid, bus.out, bus.zero} !== {1'b1, 8'hFF, 1'b0}) begin
      errors++;
      $display("[TB] FAIL zero_clear: got v=%b out=%h z=%b expected v=1 out=ff z=0",
               bus.out_valid, bus.out, bus.zero);
    end
    step();
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.x = 8'h01; bus.y = 8'h01; bus.control = 2'd1;
    step();
    bus.x = 8'h02; bus.y = 8'h00; bus.control = 2'd3;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_valid, bus.out, bus.in_ready} !== {1'b1, 8'h01, 1'b0}) begin
      errors++;
      $display("[TB] FAIL mid_loaded: got v=%b out=%h rdy=%b expected v=1 out=01 rdy=0",
               bus.out_valid, bus.out, bus.in_ready);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.out, bus.acc, bus.in_ready} !== {1'b0, 8'h00, 8'h00, 1'b1}) begin
      errors++;
      $display("[TB] FAIL mid_reset: got v=%b out=%h acc=%h rdy=%b expected v=0 out=00 acc=00 rdy=1",
               bus.out_valid, bus.out, bus.acc, bus.in_ready);
    end
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
        errors++;
        $display("[TB] FAIL mid_no_deliver[%0d]: got v=%b rdy=%b expected v=0 rdy=1",
                 k, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.control   = '0;
    bus.acc_en    = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_ops();
    test_backpressure();
    test_accumulate();
    test_zero();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logicunit_pipe.md
LOGICUNIT_PIPE -- requirements
Module: logicunit_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits (legal 1..64).
REQ-002 Parameter DEPTH, default 2, number of result pipeline stages (legal 1..4).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream presents an operation this cycle.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 x  input  WIDTH  first operand.
REQ-008 y  input  WIDTH  second operand.
REQ-009 control  input  2  operation select: 0 AND, 1 OR, 2 NOR, 3 XOR.
REQ-010 acc_en  input  1  when 1, the accumulator replaces x as first operand.
REQ-011 acc_clr  input  1  synchronous accumulator clear.
REQ-012 out_valid  output  1  result at out is valid.
REQ-013 out_ready  input  1  downstream accepts the result this cycle.
REQ-014 out  output  WIDTH  result of the oldest undelivered operation.
REQ-015 zero  output  1  1 when out is all zeros, qualified by out_valid.
REQ-016 acc  output  WIDTH  current accumulator value.

Function
REQ-017 Accept occurs in a cycle with in_valid=1 and in_ready=1; deliver occurs in a cycle with out_valid=1 and out_ready=1.
REQ-018 On accept: operand a = acc_en ? (acc_clr ? 0 : acc) : x; r = bitwise f(a, y, control), computed over all WIDTH bits with no carries.
REQ-019 r enters stage 1; each stage holds a valid bit, r, and zero = (r == 0).
REQ-020 A stage advances when the next stage is empty or is itself advancing; the last stage advances on deliver.
REQ-021 in_ready = stage 1 empty or stage 1 advancing; in_ready has no combinational dependence on in_valid.
REQ-022 Latency with no stall: an operation accepted on edge n is presented on out/out_valid after edge n+DEPTH-1 (DEPTH cycles from in_valid sample to out_valid).
REQ-023 Throughput: one operation per cycle while out_ready=1; no bubbles are inserted.
REQ-024 While out_valid=1 and out_ready=0, out, zero and out_valid hold stable.
REQ-025 Operations are delivered in acceptance order with no loss or duplication; capacity is exactly DEPTH operations.
REQ-026 acc loads r on every accept, regardless of acc_en.
REQ-027 acc_clr=1 without accept sets acc to 0; acc_clr=1 with accept sets acc to r, computed with acc treated as 0 per REQ-018.
REQ-028 When no stage holds valid data, out and zero retain their last values and out_valid=0.
REQ-029 Changes to control, x or y while not accepting have no effect on state.

Reset
REQ-030 reset=1 immediately clears all stage valid bits, out, zero and acc to 0, independent of clock.
REQ-031 During reset and on the first edge after release, in_ready=1 and out_valid=0.
REQ-032 Operations in flight when reset asserts are discarded and never delivered.

Verification (WIDTH=8, DEPTH=2)
REQ-033 Reset: assert reset mid-cycle -> out_valid=0, out=0x00, acc=0x00, in_ready=1 with no clock edge.
REQ-034 Ops: x=0xCA, y=0x0F, control 0,1,2,3 back-to-back, out_ready=1 -> out 0x0A, 0xCF, 0x30, 0xC5 on consecutive cycles; first out_valid DEPTH cycles after first accept.
REQ-035 Backpressure: out_ready=0, offer 3 ops -> 2 accepted, then in_ready=0, out held stable; raise out_ready -> 3rd accepted, all 3 delivered in order.
REQ-036 Accumulate: acc_clr with acc_en, OR, y=0x01; then acc_en, OR, y=0x02, 0x04; then XOR, y=0xFF -> outs 0x01, 0x03, 0x07, 0xF8; final acc=0xF8.
REQ-037 Zero flag: AND, x=0xF0, y=0x0F -> out=0x00, zero=1; next op OR gives zero=0.
REQ-038 Reset mid-flight: 2 ops in pipeline with out_ready=0, pulse reset -> out_valid=0, neither op ever delivered, acc=0x00.
